// File: rtl/data_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter_if
//   Bundles the two requester ports and the LC3 data-memory side of the
//   data_mem_arbiter into a single interface.
//   Modports:
//     slave  - arbiter side (receives requests, drives the memory bus)
//     master - environment side (requesters plus memory model)
//   Signals:
//     reqN_valid/rd/addr/din   request from port N (0 = CPU MemAccess, 1 = DMA)
//     reqN_done/err/dout       completion pulse, abort pulse, read data
//     Data_en/rd/addr/din      memory transaction outputs
//     Data_dout, complete_data memory read data and completion pulse
//     busy, spurious_err       status
// -----------------------------------------------------------------------------
interface data_mem_arbiter_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16
);
   logic              req0_valid;
   logic              req0_rd;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_din;
   logic              req0_done;
   logic              req0_err;
   logic [DATA_W-1:0] req0_dout;

   logic              req1_valid;
   logic              req1_rd;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_din;
   logic              req1_done;
   logic              req1_err;
   logic [DATA_W-1:0] req1_dout;

   logic              Data_en;
   logic              Data_rd;
   logic [ADDR_W-1:0] Data_addr;
   logic [DATA_W-1:0] Data_din;
   logic [DATA_W-1:0] Data_dout;
   logic              complete_data;

   logic              busy;
   logic              spurious_err;

   modport slave (
      input  req0_valid, req0_rd, req0_addr, req0_din,
      output req0_done, req0_err, req0_dout,
      input  req1_valid, req1_rd, req1_addr, req1_din,
      output req1_done, req1_err, req1_dout,
      output Data_en, Data_rd, Data_addr, Data_din,
      input  Data_dout, complete_data,
      output busy, spurious_err
   );

   modport master (
      output req0_valid, req0_rd, req0_addr, req0_din,
      input  req0_done, req0_err, req0_dout,
      output req1_valid, req1_rd, req1_addr, req1_din,
      input  req1_done, req1_err, req1_dout,
      input  Data_en, Data_rd, Data_addr, Data_din,
      output Data_dout, complete_data,
      input  busy, spurious_err
   );
endinterface

// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
//   Two-port round-robin arbiter/sequencer for the LC3 data memory. Grants one
//   requester, drives a single registered memory transaction, waits for
//   complete_data, then returns read data and a one-cycle done pulse to the
//   winner. States: IDLE -> BUSY -> DONE -> IDLE (3 cycles minimum).
//   Ports:
//     clock, reset  posedge clock, synchronous active-high reset
//     bus           data_mem_arbiter_if.slave (requester ports, memory bus,
//                   busy, sticky spurious_err)
//   Parameters: ADDR_W, DATA_W, TIMEOUT (2..65535, used only with timeout)
//   Optional feature: define DATA_MEM_ARB_TIMEOUT_EN to abort a BUSY
//   transaction after TIMEOUT cycles without completion (reqN_err pulses with
//   reqN_done). Without it BUSY waits indefinitely and reqN_err is 0.
// -----------------------------------------------------------------------------
module data_mem_arbiter #(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic              clock,
   input  logic              reset,
   data_mem_arbiter_if.slave bus
);

   if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
      $error("data_mem_arbiter: TIMEOUT must be in 2..65535");
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e            state_q,     state_d;
   logic              rr_ptr_q,    rr_ptr_d;
   logic              grant_q,     grant_d;
   logic              data_en_q,   data_en_d;
   logic              data_rd_q,   data_rd_d;
   logic [ADDR_W-1:0] data_addr_q, data_addr_d;
   logic [DATA_W-1:0] data_din_q,  data_din_d;
   logic              done0_q,     done0_d;
   logic              done1_q,     done1_d;
   logic [DATA_W-1:0] dout0_q,     dout0_d;
   logic [DATA_W-1:0] dout1_q,     dout1_d;
   logic              spur_q,      spur_d;

`ifdef DATA_MEM_ARB_TIMEOUT_EN
   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);
   logic [15:0]       cnt_q,       cnt_d;
   logic              err0_q,      err0_d;
   logic              err1_q,      err1_d;
`endif

   // Winner when arbitrating: a lone requester wins outright; a tie goes to rr_ptr.
   logic gnt_sel;
   assign gnt_sel = (bus.req0_valid && bus.req1_valid) ? rr_ptr_q : bus.req1_valid;

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_d     = grant_q;
      data_en_d   = data_en_q;
      data_rd_d   = data_rd_q;
      data_addr_d = data_addr_q;
      data_din_d  = data_din_q;
      done0_d     = 1'b0;
      done1_d     = 1'b0;
      dout0_d     = dout0_q;
      dout1_d     = dout1_q;
      spur_d      = spur_q;
`ifdef DATA_MEM_ARB_TIMEOUT_EN
      cnt_d       = cnt_q;
      err0_d      = 1'b0;
      err1_d      = 1'b0;
`endif

      unique case (state_q)
         ST_IDLE: begin
            if (bus.complete_data) spur_d = 1'b1;
            if (bus.req0_valid || bus.req1_valid) begin
               grant_d     = gnt_sel;
               data_en_d   = 1'b1;
               data_rd_d   = gnt_sel ? bus.req1_rd   : bus.req0_rd;
               data_addr_d = gnt_sel ? bus.req1_addr : bus.req0_addr;
               // Write data is only meaningful on writes; reads drive zero.
               if (gnt_sel ? bus.req1_rd : bus.req0_rd)
                  data_din_d = '0;
               else
                  data_din_d = gnt_sel ? bus.req1_din : bus.req0_din;
               state_d     = ST_BUSY;
`ifdef DATA_MEM_ARB_TIMEOUT_EN
               cnt_d       = '0;
`endif
            end
         end

         ST_BUSY: begin
            if (bus.complete_data) begin
               if (data_rd_q) begin
                  if (grant_q) dout1_d = bus.Data_dout;
                  else         dout0_d = bus.Data_dout;
               end
               done0_d   = ~grant_q;
               done1_d   = grant_q;
               data_en_d = 1'b0;
               rr_ptr_d  = ~grant_q;
               state_d   = ST_DONE;
            end
`ifdef DATA_MEM_ARB_TIMEOUT_EN
            // Completion takes priority over an abort in the same cycle.
            else if (cnt_q == CNT_LAST) begin
               done0_d   = ~grant_q;
               done1_d   = grant_q;
               err0_d    = ~grant_q;
               err1_d    = grant_q;
               data_en_d = 1'b0;
               rr_ptr_d  = ~grant_q;
               state_d   = ST_DONE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
`endif
         end

         ST_DONE: begin
            if (bus.complete_data) spur_d = 1'b1;
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= 1'b0;
         grant_q     <= 1'b0;
         data_en_q   <= 1'b0;
         data_rd_q   <= 1'b0;
         data_addr_q <= '0;
         data_din_q  <= '0;
         done0_q     <= 1'b0;
         done1_q     <= 1'b0;
         dout0_q     <= '0;
         dout1_q     <= '0;
         spur_q      <= 1'b0;
`ifdef DATA_MEM_ARB_TIMEOUT_EN
         cnt_q       <= '0;
         err0_q      <= 1'b0;
         err1_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_q     <= grant_d;
         data_en_q   <= data_en_d;
         data_rd_q   <= data_rd_d;
         data_addr_q <= data_addr_d;
         data_din_q  <= data_din_d;
         done0_q     <= done0_d;
         done1_q     <= done1_d;
         dout0_q     <= dout0_d;
         dout1_q     <= dout1_d;
         spur_q      <= spur_d;
`ifdef DATA_MEM_ARB_TIMEOUT_EN
         cnt_q       <= cnt_d;
         err0_q      <= err0_d;
         err1_q      <= err1_d;
`endif
      end
   end

   assign bus.Data_en      = data_en_q;
   assign bus.Data_rd      = data_rd_q;
   assign bus.Data_addr    = data_addr_q;
   assign bus.Data_din     = data_din_q;
   assign bus.req0_done    = done0_q;
   assign bus.req1_done    = done1_q;
   assign bus.req0_dout    = dout0_q;
   assign bus.req1_dout    = dout1_q;
   assign bus.busy         = (state_q != ST_IDLE);
   assign bus.spurious_err = spur_q;
`ifdef DATA_MEM_ARB_TIMEOUT_EN
   assign bus.req0_err     = err0_q;
   assign bus.req1_err     = err1_q;
`else
   assign bus.req0_err     = 1'b0;
   assign bus.req1_err     = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_mem_arbiter
//   Self-checking bench for data_mem_arbiter. A table of single-port
//   transactions is replayed in a loop; hand-written sequences cover
//   round-robin fairness, frozen memory outputs, spurious completion, reset
//   during BUSY and (with DATA_MEM_ARB_TIMEOUT_EN) the timeout abort.
//   Expected memory-side transactions and completions are queued when the
//   stimulus is driven and compared by negedge monitors when the DUT emits them.
// -----------------------------------------------------------------------------
module tb_data_mem_arbiter;

   logic clock;
   logic reset;

   data_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   data_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        port;
      logic        rd;
      logic [15:0] addr;
      logic [15:0] din;
      logic [15:0] rdata;
      int unsigned lat;       // BUSY cycles before the completing one
      logic [15:0] exp_dout;  // expected reqN_dout of the granted port afterwards
   } txn_t;

   typedef struct {
      logic        rd;
      logic [15:0] addr;
      logic [15:0] din;
   } mem_exp_t;

   typedef struct {
      logic [1:0]  done;
      logic [1:0]  err;
      logic [15:0] d0;
      logic [15:0] d1;
   } done_exp_t;

   mem_exp_t  mem_q[$];
   done_exp_t done_q[$];
   logic [15:0] md [2];   // model of reqN_dout

   int unsigned n_cmp  = 0;
   int unsigned n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_event(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: event seen, required none (t=%0t)", name, $time);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [1:0] onehot(input logic p);
      return p ? 2'b10 : 2'b01;
   endfunction

   task automatic drive_req(input logic p, input logic v, input logic rd,
                            input logic [15:0] addr, input logic [15:0] din);
      if (p) begin
         bus.req1_valid = v; bus.req1_rd = rd; bus.req1_addr = addr; bus.req1_din = din;
      end else begin
         bus.req0_valid = v; bus.req0_rd = rd; bus.req0_addr = addr; bus.req0_din = din;
      end
   endtask

   task automatic drop_valid(input logic p);
      if (p) bus.req1_valid = 1'b0;
      else   bus.req0_valid = 1'b0;
   endtask

   task automatic push_mem(input logic rd, input logic [15:0] addr, input logic [15:0] din);
      mem_exp_t m;
      m.rd = rd; m.addr = addr; m.din = din;
      mem_q.push_back(m);
   endtask

   task automatic push_done(input logic p, input logic [15:0] dout, input logic err);
      done_exp_t d;
      md[p]  = dout;
      d.done = onehot(p);
      d.err  = err ? onehot(p) : 2'b00;
      d.d0   = md[0];
      d.d1   = md[1];
      done_q.push_back(d);
   endtask

   // Memory-side monitor: each rising Data_en consumes one expectation, which
   // must then hold unchanged for every cycle Data_en stays high.
   logic     en_prev  = 1'b0;
   logic     have_cur = 1'b0;
   mem_exp_t cur;

   always @(negedge clock) begin
      if (bus.Data_en) begin
         if (!en_prev) begin
            if (mem_q.size() == 0) begin
               fail_event("unexpected_grant");
               have_cur = 1'b0;
            end else begin
               cur      = mem_q.pop_front();
               have_cur = 1'b1;
            end
         end
         if (have_cur) begin
            chk("mem_rd",   bus.Data_rd,   cur.rd);
            chk("mem_addr", bus.Data_addr, cur.addr);
            chk("mem_din",  bus.Data_din,  cur.din);
         end
      end
      en_prev = bus.Data_en;
   end

   // Completion monitor.
   always @(negedge clock) begin
      done_exp_t d;
      if (bus.req0_done || bus.req1_done) begin
         if (done_q.size() == 0) begin
            fail_event("unexpected_done");
         end else begin
            d = done_q.pop_front();
            chk("done_port", {bus.req1_done, bus.req0_done}, d.done);
            chk("done_err",  {bus.req1_err,  bus.req0_err},  d.err);
            chk("req0_dout", bus.req0_dout, d.d0);
            chk("req1_dout", bus.req1_dout, d.d1);
         end
      end else if (bus.req0_err || bus.req1_err) begin
         fail_event("err_without_done");
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      md[0] = '0;
      md[1] = '0;
   endtask

   task automatic run_txn(input txn_t t);
      drive_req(t.port, 1'b1, t.rd, t.addr, t.din);
      push_mem(t.rd, t.addr, t.rd ? 16'h0000 : t.din);
      push_done(t.port, t.exp_dout, 1'b0);
      tick();
      chk("en_after_grant",   bus.Data_en, 1);
      chk("busy_after_grant", bus.busy,    1);
      repeat (t.lat) tick();
      bus.complete_data = 1'b1;
      bus.Data_dout     = t.rdata;
      tick();
      bus.complete_data = 1'b0;
      bus.Data_dout     = 16'h0000;
      drop_valid(t.port);
      chk("done_pulse", {bus.req1_done, bus.req0_done}, onehot(t.port));
      chk("en_in_done", bus.Data_en, 0);
      tick();
      chk("done_cleared", {bus.req1_done, bus.req0_done}, 0);
      chk("busy_idle",    bus.busy, 0);
   endtask

   // Both ports request continuously; grants must alternate starting at port 0.
   task automatic run_rr(input int unsigned n);
      drive_req(1'b0, 1'b1, 1'b1, 16'h0010, 16'h0000);
      drive_req(1'b1, 1'b1, 1'b1, 16'h0020, 16'h0000);
      for (int unsigned k = 0; k < n; k++) begin
         logic        g;
         logic [15:0] rdata;
         g     = k[0];
         rdata = 16'hA000 + 16'(k);
         push_mem(1'b1, g ? 16'h0020 : 16'h0010, 16'h0000);
         push_done(g, rdata, 1'b0);
         tick();
         tick();
         bus.complete_data = 1'b1;
         bus.Data_dout     = rdata;
         tick();
         bus.complete_data = 1'b0;
         bus.Data_dout     = 16'h0000;
         chk("rr_grant", {bus.req1_done, bus.req0_done}, onehot(g));
         drop_valid(g);
         tick();
         if (k + 2 < n) begin
            if (g) bus.req1_valid = 1'b1;
            else   bus.req0_valid = 1'b1;
         end
      end
   endtask

   txn_t tbl [7];

   initial begin
      tbl[0] = '{1'b0, 1'b0, 16'h3000, 16'hBEEF, 16'h0000, 2, 16'h0000};
      tbl[1] = '{1'b0, 1'b1, 16'h3000, 16'h0000, 16'hBEEF, 2, 16'hBEEF};
      tbl[2] = '{1'b1, 1'b0, 16'h1234, 16'h5A5A, 16'h0000, 0, 16'h0000};
      tbl[3] = '{1'b1, 1'b1, 16'h1234, 16'h0000, 16'h5A5A, 1, 16'h5A5A};
      tbl[4] = '{1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'h1111, 3, 16'hBEEF};
      tbl[5] = '{1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000};
      tbl[6] = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h8001, 0, 16'h8001};

      bus.req0_valid = 0; bus.req0_rd = 0; bus.req0_addr = 0; bus.req0_din = 0;
      bus.req1_valid = 0; bus.req1_rd = 0; bus.req1_addr = 0; bus.req1_din = 0;
      bus.Data_dout  = 0; bus.complete_data = 0;
      md[0] = '0;
      md[1] = '0;

      // Reset state, observed while reset is still asserted.
      reset = 1'b1;
      tick();
      tick();
      chk("rst_en",       bus.Data_en,   0);
      chk("rst_busy",     bus.busy,      0);
      chk("rst_rd",       bus.Data_rd,   0);
      chk("rst_addr",     bus.Data_addr, 0);
      chk("rst_din",      bus.Data_din,  0);
      chk("rst_done",     {bus.req1_done, bus.req0_done}, 0);
      chk("rst_err",      {bus.req1_err,  bus.req0_err},  0);
      chk("rst_dout0",    bus.req0_dout, 0);
      chk("rst_dout1",    bus.req1_dout, 0);
      chk("rst_spurious", bus.spurious_err, 0);
      reset = 1'b0;
      tick();

      for (int unsigned i = 0; i < 7; i++) run_txn(tbl[i]);

      // Fairness from reset: 0,1,0,1,0,1,0,1.
      do_reset();
      run_rr(8);

      // Requester changes mid-BUSY must not reach the memory bus.
      drive_req(1'b1, 1'b1, 1'b0, 16'h0100, 16'h1111);
      push_mem(1'b0, 16'h0100, 16'h1111);
      push_done(1'b1, md[1], 1'b0);
      tick();
      bus.req1_addr = 16'h0200;
      bus.req1_din  = 16'h2222;
      bus.req1_rd   = 1'b1;
      repeat (3) tick();
      chk("frozen_addr", bus.Data_addr, 16'h0100);
      bus.complete_data = 1'b1;
      bus.Data_dout     = 16'hCAFE;
      tick();
      bus.complete_data = 1'b0;
      bus.Data_dout     = 16'h0000;
      chk("frozen_addr_done", bus.Data_addr, 16'h0100);
      chk("frozen_done",      {bus.req1_done, bus.req0_done}, 2'b10);
      drop_valid(1'b1);
      tick();

      // complete_data while IDLE: sticky error, no data effect.
      chk("spur_before", bus.spurious_err, 0);
      bus.complete_data = 1'b1;
      bus.Data_dout     = 16'hDEAD;
      tick();
      bus.complete_data = 1'b0;
      bus.Data_dout     = 16'h0000;
      chk("spur_set",   bus.spurious_err, 1);
      chk("spur_dout0", bus.req0_dout, md[0]);
      chk("spur_dout1", bus.req1_dout, md[1]);
      chk("spur_busy",  bus.busy, 0);
      tick();
      run_txn('{1'b0, 1'b1, 16'h0040, 16'h0000, 16'h7777, 1, 16'h7777});
      chk("spur_sticky", bus.spurious_err, 1);

      // Reset during BUSY of a port 1 read (rr_ptr is 1 at this point).
      drive_req(1'b1, 1'b1, 1'b1, 16'h0080, 16'h0000);
      push_mem(1'b1, 16'h0080, 16'h0000);
      tick();
      chk("rb_en_busy", bus.Data_en, 1);
      tick();
      reset = 1'b1;
      tick();
      chk("rb_en",   bus.Data_en, 0);
      chk("rb_busy", bus.busy,    0);
      chk("rb_done", {bus.req1_done, bus.req0_done}, 0);
      reset = 1'b0;
      drop_valid(1'b1);
      md[0] = '0;
      md[1] = '0;
      chk("rb_spur_clr", bus.spurious_err, 0);
      chk("rb_dout0",    bus.req0_dout, 0);
      tick();
      tick();
      run_rr(2);

`ifdef DATA_MEM_ARB_TIMEOUT_EN
      // Memory never completes: abort after 4 BUSY cycles.
      drive_req(1'b0, 1'b1, 1'b1, 16'h0500, 16'h0000);
      push_mem(1'b1, 16'h0500, 16'h0000);
      push_done(1'b0, md[0], 1'b1);
      tick();
      repeat (3) tick();
      chk("to_still_busy", bus.Data_en, 1);
      tick();
      chk("to_done", {bus.req1_done, bus.req0_done}, 2'b01);
      chk("to_err",  {bus.req1_err,  bus.req0_err},  2'b01);
      chk("to_en",   bus.Data_en, 0);
      drop_valid(1'b0);
      tick();

      // Completion on the 4th BUSY cycle beats the timeout.
      drive_req(1'b0, 1'b1, 1'b1, 16'h0600, 16'h0000);
      push_mem(1'b1, 16'h0600, 16'h0000);
      push_done(1'b0, 16'h4242, 1'b0);
      tick();
      repeat (3) tick();
      bus.complete_data = 1'b1;
      bus.Data_dout     = 16'h4242;
      tick();
      bus.complete_data = 1'b0;
      bus.Data_dout     = 16'h0000;
      chk("tc_done", {bus.req1_done, bus.req0_done}, 2'b01);
      chk("tc_err",  {bus.req1_err,  bus.req0_err},  2'b00);
      drop_valid(1'b0);
      tick();
`endif

      tick();
      tick();
      chk("mem_q_empty",  mem_q.size(),  0);
      chk("done_q_empty", done_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at t=%0t, required finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
